// File: rtl/mult_div_unit.sv
// mult_div_unit
// Sequential multiply/divide unit for the multicycle MIPS datapath. A signed
// multiply runs as a 32-step shift-add on operand magnitudes. A signed divide
// runs as a 32-step restoring division on operand magnitudes. The sign of the
// result is corrected once, at the end, and the 64-bit result goes into the
// architectural HI/LO registers.
//
// Ports
//   clk          single clock; all state changes on the rising edge
//   reset_n      synchronous, active-low reset
//   start_mult   one-cycle request for a signed multiply A*B
//   start_div    one-cycle request for a signed divide A/B
//   start_multu  one-cycle request for an unsigned multiply
//                (present only with MULTDIV_UNSIGNED_EN)
//   start_divu   one-cycle request for an unsigned divide
//                (present only with MULTDIV_UNSIGNED_EN)
//   regA_out     operand A (multiplicand / dividend)
//   regB_out     operand B (multiplier / divisor)
//   HI_out       product[63:32], or the remainder (sign of the dividend)
//   LO_out       product[31:0], or the quotient (truncated toward zero)
//   busy         high while an operation is in progress
//   done         one-cycle pulse when HI/LO are updated or a divide by zero
//                is detected
//   div_zero     sticky flag: the last DIV had B == 0
//
// Configuration macro: MULTDIV_UNSIGNED_EN adds the MULTU/DIVU requests.
// Unsigned requests use the operands as raw values and skip sign correction.
module mult_div_unit (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start_mult,
   input  logic        start_div,
`ifdef MULTDIV_UNSIGNED_EN
   input  logic        start_multu,
   input  logic        start_divu,
`endif
   input  logic [31:0] regA_out,
   input  logic [31:0] regB_out,
   output logic [31:0] HI_out,
   output logic [31:0] LO_out,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] hiWork_q, hiWork_d;
   logic [31:0] loWork_q, loWork_d;
   logic [31:0] opnd_q, opnd_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        isDiv_q, isDiv_d;
   logic        resNeg_q, resNeg_d;
   logic        dvdNeg_q, dvdNeg_d;
   logic        dzPend_q, dzPend_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        divZero_q, divZero_d;

   logic        goMult, goDiv, goUnsigned;
   logic        aNeg, bNeg;
   logic [31:0] absA, absB;
   logic [32:0] mulSum, divShift, divDiff;
   logic [63:0] product;

   // Decode the start requests by priority. The divide request is dropped
   // when a multiply request arrives at the same edge. goUnsigned is high
   // when the request that wins is MULTU or DIVU.
   always_comb begin
      goMult     = start_mult;
      goDiv      = ~start_mult & start_div;
      goUnsigned = 1'b0;
`ifdef MULTDIV_UNSIGNED_EN
      goMult     = start_mult | start_multu;
      goDiv      = ~goMult & (start_div | start_divu);
      goUnsigned = ~start_mult & (start_multu | (~start_div & start_divu));
`endif
   end

   // Magnitudes of the operands. Negating 0x80000000 gives 0x80000000, which
   // is the correct magnitude 2^31 when read as unsigned, so this case needs
   // no special handling.
   assign aNeg = regA_out[31] & ~goUnsigned;
   assign bNeg = regB_out[31] & ~goUnsigned;
   assign absA = aNeg ? (32'd0 - regA_out) : regA_out;
   assign absB = bNeg ? (32'd0 - regB_out) : regB_out;

   // One multiply step. The multiplier sits in loWork and moves out to the
   // right while product bits move in from the top. When all 32 steps are
   // done, {hiWork, loWork} holds the unsigned 64-bit product.
   assign mulSum = {1'b0, hiWork_q} + (loWork_q[0] ? {1'b0, opnd_q} : 33'd0);

   // One restoring divide step. The partial remainder in hiWork takes in the
   // next dividend bit from loWork. The quotient bits move into loWork from
   // the right. A negative trial difference means the subtraction is
   // discarded.
   assign divShift = {hiWork_q, loWork_q[31]};
   assign divDiff  = divShift - {1'b0, opnd_q};

   // The product is negated once, at the end, when the operand signs differ.
   assign product  = resNeg_q ? (64'd0 - {hiWork_q, loWork_q}) : {hiWork_q, loWork_q};

   // Next-state logic and datapath updates. Every value holds by default.
   // done is a pulse, so it defaults low.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hiWork_d  = hiWork_q;
      loWork_d  = loWork_q;
      opnd_d    = opnd_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      isDiv_d   = isDiv_q;
      resNeg_d  = resNeg_q;
      dvdNeg_d  = dvdNeg_q;
      dzPend_d  = dzPend_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      divZero_d = divZero_q;

      case (state_q)
         IDLE: begin
            if (goMult || goDiv) begin
               isDiv_d   = goDiv;
               resNeg_d  = aNeg ^ bNeg;
               dvdNeg_d  = aNeg;
               cnt_d     = 5'd0;
               divZero_d = 1'b0;
               busy_d    = 1'b1;
               hiWork_d  = 32'd0;
               if (goDiv) begin
                  loWork_d = absA;
                  opnd_d   = absB;
                  dzPend_d = (regB_out == 32'd0);
                  state_d  = (regB_out == 32'd0) ? FINISH : RUN;
               end else begin
                  loWork_d = absB;
                  opnd_d   = absA;
                  dzPend_d = 1'b0;
                  state_d  = RUN;
               end
            end
         end

         RUN: begin
            if (isDiv_q) begin
               if (!divDiff[32]) begin
                  hiWork_d = divDiff[31:0];
                  loWork_d = {loWork_q[30:0], 1'b1};
               end else begin
                  hiWork_d = divShift[31:0];
                  loWork_d = {loWork_q[30:0], 1'b0};
               end
            end else begin
               hiWork_d = mulSum[32:1];
               loWork_d = {mulSum[0], loWork_q[31:1]};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = FINISH;
            end
         end

         FINISH: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (dzPend_q) begin
               divZero_d = 1'b1;
            end else if (isDiv_q) begin
               lo_d = resNeg_q ? (32'd0 - loWork_q) : loWork_q;
               hi_d = dvdNeg_q ? (32'd0 - hiWork_q) : hiWork_q;
            end else begin
               hi_d = product[63:32];
               lo_d = product[31:0];
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register. Reset also aborts an operation that is in flight and
   // clears HI/LO.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= 5'd0;
         hiWork_q  <= 32'd0;
         loWork_q  <= 32'd0;
         opnd_q    <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         isDiv_q   <= 1'b0;
         resNeg_q  <= 1'b0;
         dvdNeg_q  <= 1'b0;
         dzPend_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         divZero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hiWork_q  <= hiWork_d;
         loWork_q  <= loWork_d;
         opnd_q    <= opnd_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         isDiv_q   <= isDiv_d;
         resNeg_q  <= resNeg_d;
         dvdNeg_q  <= dvdNeg_d;
         dzPend_q  <= dzPend_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         divZero_q <= divZero_d;
      end
   end

   assign HI_out   = hi_q;
   assign LO_out   = lo_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = divZero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
// Self-checking bench for mult_div_unit. It applies a table of directed
// vectors, then randomized operations that are checked against an arithmetic
// reference model, then hand-written sequences: divide by zero, ignored
// starts, simultaneous starts, and reset in the middle of an operation.
// Define MULTDIV_UNSIGNED_EN to also cover MULTU/DIVU.
module tb_mult_div_unit;

   localparam int OP_MULT  = 0;
   localparam int OP_DIV   = 1;
   localparam int OP_MULTU = 2;
   localparam int OP_DIVU  = 3;

   logic        clk;
   logic        reset_n;
   logic        start_mult;
   logic        start_div;
`ifdef MULTDIV_UNSIGNED_EN
   logic        start_multu;
   logic        start_divu;
`endif
   logic [31:0] regA_out;
   logic [31:0] regB_out;
   logic [31:0] HI_out;
   logic [31:0] LO_out;
   logic        busy;
   logic        done;
   logic        div_zero;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      int          op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expHi;
      logic [31:0] expLo;
   } vec_t;

   vec_t vecs[$];

   mult_div_unit dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start_mult (start_mult),
      .start_div  (start_div),
`ifdef MULTDIV_UNSIGNED_EN
      .start_multu(start_multu),
      .start_divu (start_divu),
`endif
      .regA_out   (regA_out),
      .regB_out   (regB_out),
      .HI_out     (HI_out),
      .LO_out     (LO_out),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog: stops the run if the bench itself gets stuck.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compares one value against the value the bench requires and keeps the
   // counters that the summary line prints.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   // Reference result {HI, LO}, computed with plain 64-bit arithmetic.
   function automatic logic [63:0] refModel(input int op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sa, sb, p, q, r;
      longint unsigned ua, ub, up, uq, ur;
      logic [63:0]     res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      res = 64'd0;
      case (op)
         OP_MULT: begin
            p   = sa * sb;
            res = p;
         end
         OP_DIV: begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
         end
         OP_MULTU: begin
            up  = ua * ub;
            res = up;
         end
         default: begin
            uq  = ua / ub;
            ur  = ua % ub;
            res = {ur[31:0], uq[31:0]};
         end
      endcase
      return res;
   endfunction

   task automatic clearStarts();
      start_mult = 1'b0;
      start_div  = 1'b0;
`ifdef MULTDIV_UNSIGNED_EN
      start_multu = 1'b0;
      start_divu  = 1'b0;
`endif
   endtask

   // Issues one start pulse and waits, with a cycle budget, for done. The
   // cycle count k is the number of edges after the start edge E0. The task
   // returns the latency, the number of sampled busy cycles, and the state
   // right after the start and one cycle after done.
   task automatic applyStimulus(input int op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output int lat, output int busyCyc,
                                output logic busyAtDone, output logic doneAfter,
                                output logic dzAtStart);
      int k;
      regA_out = a;
      regB_out = b;
      start_mult = (op == OP_MULT);
      start_div  = (op == OP_DIV);
`ifdef MULTDIV_UNSIGNED_EN
      start_multu = (op == OP_MULTU);
      start_divu  = (op == OP_DIVU);
`endif
      @(negedge clk);
      clearStarts();
      dzAtStart = div_zero;
      k = 0;
      busyCyc = 0;
      while (!done && k < 100) begin
         if (busy) busyCyc++;
         @(negedge clk);
         k++;
      end
      lat        = k;
      hi         = HI_out;
      lo         = LO_out;
      busyAtDone = busy;
      @(negedge clk);
      doneAfter  = done;
   endtask

   initial begin
      logic [31:0] hi, lo, preHi, preLo;
      logic        busyAtDone, doneAfter, dzAtStart;
      logic [63:0] expRes;
      int          lat, busyCyc, dones, op, nOps;
      logic [31:0] a, b;

      reset_n  = 1'b0;
      regA_out = 32'd0;
      regB_out = 32'd0;
      clearStarts();
      repeat (2) @(negedge clk);

      // Reset state.
      checkOutput("reset_HI",       {32'd0, HI_out}, 64'd0);
      checkOutput("reset_LO",       {32'd0, LO_out}, 64'd0);
      checkOutput("reset_busy",     {63'd0, busy},   64'd0);
      checkOutput("reset_done",     {63'd0, done},   64'd0);
      checkOutput("reset_div_zero", {63'd0, div_zero}, 64'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Directed vectors with hand-computed results.
      vecs.push_back('{OP_MULT, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB});
      vecs.push_back('{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
      vecs.push_back('{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
      vecs.push_back('{OP_MULT, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C});
      vecs.push_back('{OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});
      vecs.push_back('{OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
      vecs.push_back('{OP_MULT, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000});
      vecs.push_back('{OP_DIV,  32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2});
      vecs.push_back('{OP_DIV,  32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2});
      vecs.push_back('{OP_DIV,  32'h00000005, 32'h0000000A, 32'h00000005, 32'h00000000});
`ifdef MULTDIV_UNSIGNED_EN
      vecs.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
      vecs.push_back('{OP_DIVU,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h7FFFFFFF});
`endif

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, lat, busyCyc,
                       busyAtDone, doneAfter, dzAtStart);
         checkOutput($sformatf("vec%0d_HI", i), {32'd0, hi}, {32'd0, vecs[i].expHi});
         checkOutput($sformatf("vec%0d_LO", i), {32'd0, lo}, {32'd0, vecs[i].expLo});
         checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
         checkOutput($sformatf("vec%0d_busy_cycles", i), 64'(busyCyc), 64'd33);
         checkOutput($sformatf("vec%0d_busy_at_done", i), {63'd0, busyAtDone}, 64'd0);
         checkOutput($sformatf("vec%0d_done_width", i), {63'd0, doneAfter}, 64'd0);
         checkOutput($sformatf("vec%0d_div_zero", i), {63'd0, div_zero}, 64'd0);
      end

      // Randomized operations checked against the reference model.
`ifdef MULTDIV_UNSIGNED_EN
      nOps = 4;
`else
      nOps = 2;
`endif
      for (int i = 0; i < 30; i++) begin
         op = int'($urandom_range(0, nOps - 1));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
         if ($urandom_range(0, 7) == 0) a = 32'h80000000;
         if ((op == OP_DIV || op == OP_DIVU) && b == 32'd0) b = 32'd1;
         expRes = refModel(op, a, b);
         applyStimulus(op, a, b, hi, lo, lat, busyCyc, busyAtDone, doneAfter, dzAtStart);
         checkOutput($sformatf("rand%0d_op%0d_result", i, op), {hi, lo}, expRes);
         checkOutput($sformatf("rand%0d_latency", i), 64'(lat), 64'd33);
      end

      // Divide by zero: HI/LO keep the values from a preceding multiply.
      applyStimulus(OP_MULT, 32'd7, 32'hFFFFFFFD, preHi, preLo, lat, busyCyc,
                    busyAtDone, doneAfter, dzAtStart);
      applyStimulus(OP_DIV, 32'd1234, 32'd0, hi, lo, lat, busyCyc,
                    busyAtDone, doneAfter, dzAtStart);
      checkOutput("dz_latency",      64'(lat), 64'd1);
      checkOutput("dz_busy_cycles",  64'(busyCyc), 64'd1);
      checkOutput("dz_busy_at_done", {63'd0, busyAtDone}, 64'd0);
      checkOutput("dz_flag",         {63'd0, div_zero}, 64'd1);
      checkOutput("dz_HI_kept",      {32'd0, hi}, 64'h00000000FFFFFFFF);
      checkOutput("dz_LO_kept",      {32'd0, lo}, 64'h00000000FFFFFFEB);
      applyStimulus(OP_MULT, 32'd2, 32'd3, hi, lo, lat, busyCyc,
                    busyAtDone, doneAfter, dzAtStart);
      checkOutput("dz_cleared_at_start", {63'd0, dzAtStart}, 64'd0);
      checkOutput("dz_next_result", {hi, lo}, 64'd6);

      // A divide request during a multiply is ignored.
      regA_out   = 32'd5;
      regB_out   = 32'd6;
      start_mult = 1'b1;
      @(negedge clk);
      clearStarts();
      dones = 0;
      hi = 32'd0;
      lo = 32'd0;
      for (int k = 0; k < 60; k++) begin
         if (k == 4) begin
            regA_out  = 32'd100;
            regB_out  = 32'd7;
            start_div = 1'b1;
         end
         if (k == 5) start_div = 1'b0;
         if (done) begin
            dones++;
            hi = HI_out;
            lo = LO_out;
         end
         @(negedge clk);
      end
      checkOutput("overlap_done_count", 64'(dones), 64'd1);
      checkOutput("overlap_result", {hi, lo}, 64'd30);

      // Simultaneous requests at idle: only the multiply runs.
      regA_out   = 32'hFFFFFFFA;
      regB_out   = 32'd5;
      start_mult = 1'b1;
      start_div  = 1'b1;
      @(negedge clk);
      clearStarts();
      dones = 0;
      for (int k = 0; k < 60; k++) begin
         if (done) begin
            dones++;
            hi = HI_out;
            lo = LO_out;
         end
         @(negedge clk);
      end
      checkOutput("both_done_count", 64'(dones), 64'd1);
      checkOutput("both_result", {hi, lo}, 64'hFFFFFFFFFFFFFFE2);

      // Reset at E0+10 of a divide aborts it and clears everything.
      regA_out  = 32'd1000;
      regB_out  = 32'd3;
      start_div = 1'b1;
      @(negedge clk);
      clearStarts();
      repeat (9) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      checkOutput("midreset_HI",       {32'd0, HI_out}, 64'd0);
      checkOutput("midreset_LO",       {32'd0, LO_out}, 64'd0);
      checkOutput("midreset_busy",     {63'd0, busy}, 64'd0);
      checkOutput("midreset_done",     {63'd0, done}, 64'd0);
      checkOutput("midreset_div_zero", {63'd0, div_zero}, 64'd0);
      reset_n = 1'b1;
      @(negedge clk);
      applyStimulus(OP_MULT, 32'd3, 32'd4, hi, lo, lat, busyCyc,
                    busyAtDone, doneAfter, dzAtStart);
      checkOutput("postreset_result",  {hi, lo}, 64'd12);
      checkOutput("postreset_latency", 64'(lat), 64'd33);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
